// File: rtl/pwm_duty_register_bank.sv
// pwm_duty_register_bank
//   Multi-channel, double-buffered duty-cycle register bank for a PWM
//   modulator. Writes land in a per-channel shadow register. The active
//   value seen by the comparator follows the shadow only at a PWM period
//   boundary, either by jumping directly or by ramping in steps of at most
//   SLEW_STEP per period.
//
// Ports
//   Clock          system clock, rising edge
//   Reset_n        asynchronous active-low reset; all duties return to STEP
//   Write_En       one-cycle write strobe
//   Write_Channel  target channel index (CH_W bits)
//   Write_Mode     0 = quantised level write, 1 = raw duty write
//   Write_Level    level index; duty = (Write_Level+1)*STEP
//   Write_Raw      raw duty value for Write_Mode=1
//   Period_End     one-cycle pulse at the PWM counter wrap
//   Slew_Enable    1 = ramp active toward shadow, 0 = jump
//   Register_Data  packed active duties, channel i at [i*DATA_W +: DATA_W]
//   Update_Pending per-channel (active != shadow), combinational
//   Write_Error    registered one-cycle pulse on an out-of-range channel
module pwm_duty_register_bank #(
  parameter int CHANNELS  = 4,
  parameter int DATA_W    = 8,
  parameter int SEL_W     = 2,
  parameter int SLEW_STEP = 16,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         Clock,
  input  logic                         Reset_n,
  input  logic                         Write_En,
  input  logic [CH_W-1:0]              Write_Channel,
  input  logic                         Write_Mode,
  input  logic [SEL_W-1:0]             Write_Level,
  input  logic [DATA_W-1:0]            Write_Raw,
  input  logic                         Period_End,
  input  logic                         Slew_Enable,
  output logic [CHANNELS*DATA_W-1:0]   Register_Data,
  output logic [CHANNELS-1:0]          Update_Pending,
  output logic                         Write_Error
);

  localparam int LEVELS = 1 << SEL_W;
  localparam int STEP   = (1 << DATA_W) / (LEVELS + 1);
  localparam int PROD_W = DATA_W + SEL_W;

  localparam logic [DATA_W-1:0] STEP_D   = DATA_W'(STEP);
  localparam logic [PROD_W-1:0] STEP_P   = PROD_W'(STEP);
  localparam logic [DATA_W:0]   SLEW_G   = (DATA_W+1)'(SLEW_STEP);
  localparam logic [CH_W:0]     CH_LIMIT = (CH_W+1)'(CHANNELS);

  logic [DATA_W-1:0] shadow_q [CHANNELS];
  logic [DATA_W-1:0] shadow_d [CHANNELS];
  logic [DATA_W-1:0] active_q [CHANNELS];
  logic [DATA_W-1:0] active_d [CHANNELS];
  logic              write_error_q;
  logic              write_error_d;

  logic              wr_in_range;
  logic [DATA_W-1:0] wr_value;

  // One slew step from act toward tgt. The difference is formed with a
  // guard bit so it never wraps; when the remaining distance fits within
  // SLEW_STEP the target is returned exactly, so the ramp cannot overshoot.
  function automatic logic [DATA_W-1:0] slew_toward(
    input logic [DATA_W-1:0] act,
    input logic [DATA_W-1:0] tgt
  );
    logic [DATA_W:0] diff;
    if (tgt > act) begin
      diff = {1'b0, tgt} - {1'b0, act};
      if (diff > SLEW_G) return act + SLEW_G[DATA_W-1:0];
      else               return tgt;
    end else begin
      diff = {1'b0, act} - {1'b0, tgt};
      if (diff > SLEW_G) return act - SLEW_G[DATA_W-1:0];
      else               return tgt;
    end
  endfunction

  always_comb begin
    wr_in_range   = ({1'b0, Write_Channel} < CH_LIMIT);
    // Level product is formed at DATA_W+SEL_W bits; STEP is chosen so the
    // top level still fits in DATA_W, so the truncation drops only zeros.
    wr_value      = Write_Mode ? Write_Raw
                               : DATA_W'((PROD_W'(Write_Level) + PROD_W'(1)) * STEP_P);
    write_error_d = Write_En && !wr_in_range;
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      // Active update reads the pre-write shadow, so a write coinciding
      // with Period_End only takes effect at the following boundary.
      if (Period_End && (active_q[i] != shadow_q[i])) begin
        active_d[i] = Slew_Enable ? slew_toward(active_q[i], shadow_q[i])
                                  : shadow_q[i];
      end
      if (Write_En && wr_in_range && (Write_Channel == CH_W'(i))) begin
        shadow_d[i] = wr_value;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= STEP_D;
        active_q[i] <= STEP_D;
      end
      write_error_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      write_error_q <= write_error_d;
    end
  end

  always_comb begin
    Register_Data  = '0;
    Update_Pending = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      Register_Data[i*DATA_W +: DATA_W] = active_q[i];
      Update_Pending[i]                 = (active_q[i] != shadow_q[i]);
    end
  end

  assign Write_Error = write_error_q;

endmodule

// File: tb/tb_pwm_duty_register_bank.sv
// Testbench for pwm_duty_register_bank. Five channels so that channel
// indices 5..7 are addressable and exercise the out-of-range error path.
module tb_pwm_duty_register_bank;

  localparam int NCH  = 5;
  localparam int DW   = 8;
  localparam int SW   = 2;
  localparam int SLEW = 16;
  localparam int CW   = 3;
  localparam int STEP = 51;

  logic                Clock = 1'b0;
  logic                Reset_n;
  logic                Write_En;
  logic [CW-1:0]       Write_Channel;
  logic                Write_Mode;
  logic [SW-1:0]       Write_Level;
  logic [DW-1:0]       Write_Raw;
  logic                Period_End;
  logic                Slew_Enable;
  logic [NCH*DW-1:0]   Register_Data;
  logic [NCH-1:0]      Update_Pending;
  logic                Write_Error;

  pwm_duty_register_bank #(
    .CHANNELS (NCH),
    .DATA_W   (DW),
    .SEL_W    (SW),
    .SLEW_STEP(SLEW)
  ) dut (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .Write_En      (Write_En),
    .Write_Channel (Write_Channel),
    .Write_Mode    (Write_Mode),
    .Write_Level   (Write_Level),
    .Write_Raw     (Write_Raw),
    .Period_End    (Period_End),
    .Slew_Enable   (Slew_Enable),
    .Register_Data (Register_Data),
    .Update_Pending(Update_Pending),
    .Write_Error   (Write_Error)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integers for shadow/active per channel.
  int m_sh  [NCH];
  int m_act [NCH];
  int m_err;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lane(input int i);
    return int'(Register_Data[i*DW +: DW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh[i]  = STEP;
      m_act[i] = STEP;
    end
    m_err = 0;
  endtask

  // Apply one rising edge of the specified behaviour to the model.
  task automatic model_edge();
    int ch;
    int delta;
    for (int i = 0; i < NCH; i++) begin
      if (Period_End && m_act[i] != m_sh[i]) begin
        delta = m_sh[i] - m_act[i];
        if (!Slew_Enable || delta <= SLEW && delta >= -SLEW) m_act[i] = m_sh[i];
        else if (delta > 0) m_act[i] = m_act[i] + SLEW;
        else                m_act[i] = m_act[i] - SLEW;
      end
    end
    ch = int'(Write_Channel);
    m_err = (Write_En && ch >= NCH) ? 1 : 0;
    if (Write_En && ch < NCH)
      m_sh[ch] = Write_Mode ? int'(Write_Raw) : (int'(Write_Level) + 1) * STEP;
  endtask

  task automatic compare_all(input string phase);
    int pend;
    pend = 0;
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("%s lane%0d", phase, i), lane(i), m_act[i]);
      if (m_act[i] != m_sh[i]) pend = pend | (1 << i);
    end
    chk({phase, " pending"}, int'(Update_Pending), pend);
    chk({phase, " werr"}, int'(Write_Error), m_err);
  endtask

  task automatic tick(input string phase);
    @(posedge Clock);
    model_edge();
    #1;
    compare_all(phase);
    Write_En   = 1'b0;
    Period_End = 1'b0;
  endtask

  task automatic wr(input int ch, input bit mode, input int lvl, input int raw);
    Write_En      = 1'b1;
    Write_Channel = CW'(ch);
    Write_Mode    = mode;
    Write_Level   = SW'(lvl);
    Write_Raw     = DW'(raw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int periods;
    Reset_n = 1'b0;
    Write_En = 1'b0; Write_Channel = '0; Write_Mode = 1'b0;
    Write_Level = '0; Write_Raw = '0; Period_End = 1'b0; Slew_Enable = 1'b0;
    model_reset();
    #12;
    Reset_n = 1'b1;
    #1;
    // Reset state
    for (int i = 0; i < NCH; i++) chk($sformatf("reset lane%0d", i), lane(i), 51);
    chk("reset pending", int'(Update_Pending), 0);
    chk("reset werr", int'(Write_Error), 0);

    // Level write, held without a period boundary
    wr(2, 1'b0, 3, 0);
    tick("lvlwr");
    for (int k = 0; k < 10; k++) tick("hold");
    chk("hold lane2", lane(2), 51);
    chk("hold pend2", int'(Update_Pending[2]), 1);
    Period_End = 1'b1;
    tick("pe");
    chk("jump lane2", lane(2), 204);
    chk("jump pend2", int'(Update_Pending[2]), 0);

    // Slewed ramp up 51 -> 250, then down to 51
    Slew_Enable = 1'b1;
    wr(1, 1'b1, 0, 250);
    tick("rawwr");
    periods = 0;
    while (Update_Pending[1] && periods < 20) begin
      Period_End = 1'b1;
      tick("rampup");
      periods++;
      if (periods == 1) chk("ramp first", lane(1), 67);
      if (periods == 12) chk("ramp 12", lane(1), 243);
    end
    chk("ramp up periods", periods, 13);
    chk("ramp up final", lane(1), 250);
    wr(1, 1'b1, 0, 51);
    tick("rawwr2");
    periods = 0;
    while (Update_Pending[1] && periods < 20) begin
      Period_End = 1'b1;
      tick("rampdn");
      periods++;
      if (periods == 1) chk("rampdn first", lane(1), 234);
    end
    chk("ramp dn periods", periods, 13);
    chk("ramp dn final", lane(1), 51);

    // Write coinciding with Period_End on the same channel
    Slew_Enable = 1'b0;
    wr(0, 1'b0, 2, 0);
    tick("pre153");
    wr(0, 1'b0, 1, 0);
    Period_End = 1'b1;
    tick("coinc");
    chk("coinc lane0", lane(0), 153);
    chk("coinc pend0", int'(Update_Pending[0]), 1);
    Period_End = 1'b1;
    tick("coinc2");
    chk("coinc2 lane0", lane(0), 102);

    // Out-of-range channel
    wr(6, 1'b1, 0, 9);
    tick("oor");
    chk("oor werr", int'(Write_Error), 1);
    tick("oor2");
    chk("oor werr clr", int'(Write_Error), 0);

    // Asynchronous reset in the middle of a ramp
    Slew_Enable = 1'b1;
    wr(1, 1'b1, 0, 250);
    tick("ramp3");
    for (int k = 0; k < 3; k++) begin
      Period_End = 1'b1;
      tick("ramp3pe");
    end
    #2;
    Reset_n = 1'b0;
    #1;
    for (int i = 0; i < NCH; i++) chk($sformatf("arst lane%0d", i), lane(i), 51);
    chk("arst pending", int'(Update_Pending), 0);
    model_reset();
    @(posedge Clock);
    #2;
    Reset_n = 1'b1;

    // Randomised traffic against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                                        $urandom_range(0, 3), $urandom_range(0, 255));
      Period_End = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) Slew_Enable = ~Slew_Enable;
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
